// File: rtl/div_seq.sv
// div_seq: radix-2 restoring RV32M divide/remainder sequencer with pipeline stall and one-cycle done.
// Define DIV_EARLY_OUT_EN to skip the iterations for divide-by-zero and signed overflow.
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic            sel_rem, neg_q, neg_r;
    logic [XLEN-1:0] dvd, dvs, rem, res;
    logic            sgn, b_zero, ovf, ge;
    logic [XLEN-1:0] a_abs, b_abs, spec_res, rem_n, quo_n, q_fix, r_fix;
    logic [XLEN:0]   rem_sh;

    assign sgn      = ~op[0];
    assign b_zero   = b == '0;
    assign ovf      = sgn & (a == MIN) & (&b);
    assign a_abs    = (sgn & a[XLEN-1]) ? -a : a;
    assign b_abs    = (sgn & b[XLEN-1]) ? -b : b;
    assign spec_res = op[1] ? (b_zero ? a : '0) : (b_zero ? '1 : MIN);

    // A zero divisor naturally yields an all-ones quotient and |a| remainder; only the quotient negation must be suppressed.
    assign rem_sh = {rem, dvd[XLEN-1]};
    assign ge     = rem_sh >= {1'b0, dvs};
    assign rem_n  = ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
    assign quo_n  = {dvd[XLEN-2:0], ge};
    assign q_fix  = neg_q ? -quo_n : quo_n;
    assign r_fix  = neg_r ? -rem_n : rem_n;

    assign busy   = state != S_IDLE;
    assign stall  = (state == S_IDLE & start & ~flush) | (state == S_CALC);
    assign done   = state == S_DONE;
    assign result = res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            res     <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (state == S_IDLE) begin
            if (start && EARLY && (b_zero || ovf)) begin
                state <= S_DONE;
                res   <= spec_res;
            end else if (start) begin
                state   <= S_CALC;
                cnt     <= CW'(XLEN - 1);
                sel_rem <= op[1];
                neg_q   <= sgn & (a[XLEN-1] ^ b[XLEN-1]) & ~b_zero;
                neg_r   <= sgn & a[XLEN-1];
                dvd     <= a_abs;
                dvs     <= b_abs;
                rem     <= '0;
            end
        end else if (state == S_CALC) begin
            rem <= rem_n;
            dvd <= quo_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                state <= S_DONE;
                res   <= sel_rem ? r_fix : q_fix;
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks of div_seq against an arithmetic reference model.
module tb_div_seq;
    localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0, rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic        busy, stall, done;
    int          cmp = 0, errs = 0;

    div_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic bit special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return y == 0 || (!o[0] && x == MIN && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == MIN && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : MIN;
        case (o)
            2'd0: return $signed(x) / $signed(y);
            2'd1: return x / y;
            2'd2: return $signed(x) % $signed(y);
            default: return x % y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Starts an op at the current negedge and follows it through DONE back to IDLE.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int cyc, lat;
        bit st_ok;
        logic [31:0] e;
        e = model(o, x, y);
        lat = (EARLY && special(o, x, y)) ? 1 : 33;
        op = o; a = x; b = y; start = 1'b1;
        #1;
        chk("stall_c0", 32'(stall), 1);
        chk("busy_c0", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 1; st_ok = 1'b1;
        while (!done && cyc < 100) begin
            st_ok &= stall & busy;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("stall_held", 32'(st_ok), 1);
        chk("result", result, e);
        chk("done_stall", 32'(stall), 0);
        chk("done_busy", 32'(busy), 1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("result_hold", result, e);
    endtask

    initial begin
        int n;
        logic [1:0] o;
        logic [31:0] x, y, prior;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        run(2'd0, 32'hFFFF_FFF9, 32'd2);
        run(2'd2, 32'hFFFF_FFF9, 32'd2);
        run(2'd3, 32'd7, 32'hFFFF_FFFE);
        run(2'd1, 32'hFFFF_FFFF, 32'd16);
        run(2'd0, 32'd5, 32'd0);
        run(2'd2, 32'd5, 32'd0);
        run(2'd0, MIN, 32'hFFFF_FFFF);
        run(2'd2, MIN, 32'hFFFF_FFFF);

        // flush at cycle 10 aborts silently, restart at cycle 11
        prior = result;
        op = 2'd1; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0;
        for (int c = 1; c < 10; c++) begin
            n += int'(done);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_done", 32'(done | (n != 0)), 0);
        chk("flush_result", result, prior);
        run(2'd1, 32'd100, 32'd7);

        // start and flush together are ignored
        op = 2'd0; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        chk("sf_stall", 32'(stall), 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("sf_busy", 32'(busy), 0);

        // start while busy is ignored
        op = 2'd0; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0;
        for (int c = 1; c < 45; c++) begin
            if (c == 3) begin op = 2'd3; a = 32'd7; b = 32'd5; start = 1'b1; end
            if (c == 4) start = 1'b0;
            n += int'(done);
            @(negedge clk);
        end
        chk("busy_start_pulses", 32'(n), 1);
        chk("busy_start_result", result, 32'hFFFF_FFFD);

        // reset mid-operation
        op = 2'd1; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_result", result, 0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: begin x = MIN; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 20);
                3: begin x = $urandom_range(0, 500); y = $urandom; end
                default: y = $urandom;
            endcase
            run(o, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
